// File: rtl/majority_voter_pkg.sv
// Shared constants for the TMR majority voter.
// Lane indices select the bit of the disagree vector and the
// counter that belongs to each replicated lane.
package majority_voter_pkg;

  localparam int unsigned NUM_LANES = 3;
  localparam int unsigned LANE_A    = 0;
  localparam int unsigned LANE_B    = 1;
  localparam int unsigned LANE_C    = 2;

endpackage : majority_voter_pkg

// File: rtl/majority_voter_lane_cnt.sv
// Per-lane saturating disagreement counter.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   en         : count enable
//   clr        : synchronous clear (overrides en)
//   hit        : this lane disagreed with the vote this cycle
//   cnt        : saturating count of enabled hit cycles
module majority_voter_lane_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             hit,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Reset beats clear beats count; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && hit && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule : majority_voter_lane_cnt

// File: rtl/majority_voter.sv
// Triple-modular-redundancy voter with per-lane disagreement diagnostics.
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset
//   a, b, c      : replicated lanes, WIDTH bits each
//   en           : diagnostic update enable
//   clr          : synchronous clear of counters and sticky flag
//   y            : combinational bitwise 2-of-3 majority
//   y_q          : y delayed by one clock
//   disagree     : combinational per-lane mismatch {C,B,A}
//   cnt_a/b/c    : saturating per-lane disagreement counters
//   sticky_fault : set by any enabled disagreement, held until clr/reset
module majority_voter
  import majority_voter_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [2:0]       disagree,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic             sticky_fault
);

  // Zero-latency vote; downstream logic sees the voted value this cycle.
  assign y = (a & b) | (a & c) | (b & c);

  // A lane is flagged if any of its bits differs from the vote.
  assign disagree[LANE_A] = |(a ^ y);
  assign disagree[LANE_B] = |(b ^ y);
  assign disagree[LANE_C] = |(c ^ y);

  // Registered copy of the vote, independent of en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y;
    end
  end

  // Sticky flag: clear wins over a simultaneous fault.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_fault <= 1'b0;
    end else if (clr) begin
      sticky_fault <= 1'b0;
    end else if (en && (disagree != 3'b000)) begin
      sticky_fault <= 1'b1;
    end
  end

  majority_voter_lane_cnt #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .hit   (disagree[LANE_A]),
    .cnt   (cnt_a)
  );

  majority_voter_lane_cnt #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .hit   (disagree[LANE_B]),
    .cnt   (cnt_b)
  );

  majority_voter_lane_cnt #(.CNT_W(CNT_W)) u_cnt_c (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .hit   (disagree[LANE_C]),
    .cnt   (cnt_c)
  );

endmodule : majority_voter

// File: tb/tb_majority_voter.sv
// Bench for majority_voter: a WIDTH=4/CNT_W=8 instance and a
// WIDTH=1/CNT_W=2 instance share clock and control, each checked
// against a per-bit vote-counting reference model.
module tb_majority_voter;

  logic clk;
  logic rst_n;
  logic en;
  logic clr;

  // WIDTH=4, CNT_W=8 instance
  logic [3:0] a4, b4, c4, y_w4, yq_w4;
  logic [2:0] dis_w4;
  logic [7:0] ca_w4, cb_w4, cc_w4;
  logic       st_w4;

  // WIDTH=1, CNT_W=2 instance
  logic [0:0] a1, b1, c1, y_w1, yq_w1;
  logic [2:0] dis_w1;
  logic [1:0] ca_w1, cb_w1, cc_w1;
  logic       st_w1;

  int total;
  int bad;

  // Reference state: index 0 = wide instance, 1 = narrow instance
  int         m_cnt [2][3];
  bit         m_st  [2];
  logic [3:0] m_yq  [2];
  int         m_max [2];

  majority_voter #(.WIDTH(4), .CNT_W(8)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c(c4), .en(en), .clr(clr),
    .y(y_w4), .y_q(yq_w4), .disagree(dis_w4),
    .cnt_a(ca_w4), .cnt_b(cb_w4), .cnt_c(cc_w4), .sticky_fault(st_w4)
  );

  majority_voter #(.WIDTH(1), .CNT_W(2)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .en(en), .clr(clr),
    .y(y_w1), .y_q(yq_w1), .disagree(dis_w1),
    .cnt_a(ca_w1), .cnt_b(cb_w1), .cnt_c(cc_w1), .sticky_fault(st_w1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Each output bit is 1 when at least two of the three lane bits are 1.
  function automatic logic [3:0] vote(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i] = (ones >= 2);
    end
    return r;
  endfunction

  function automatic logic [2:0] lanes_off(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] c, input logic [3:0] y);
    return {c != y, b != y, a != y};
  endfunction

  task automatic model_update(input int k, input logic [3:0] y, input logic [2:0] d);
    if (!rst_n) begin
      for (int l = 0; l < 3; l++) m_cnt[k][l] = 0;
      m_st[k] = 0;
      m_yq[k] = '0;
    end else begin
      m_yq[k] = y;
      if (clr) begin
        for (int l = 0; l < 3; l++) m_cnt[k][l] = 0;
        m_st[k] = 0;
      end else if (en) begin
        for (int l = 0; l < 3; l++)
          if (d[l] && m_cnt[k][l] < m_max[k]) m_cnt[k][l] = m_cnt[k][l] + 1;
        if (d != 3'b000) m_st[k] = 1;
      end
    end
  endtask

  // Check combinational outputs, advance one clock, check registered outputs.
  task automatic cycle();
    logic [3:0] y0, y1;
    logic [2:0] d0, d1;
    #1;
    y0 = vote(a4, b4, c4);
    d0 = lanes_off(a4, b4, c4, y0);
    y1 = vote({3'b0, a1}, {3'b0, b1}, {3'b0, c1});
    d1 = lanes_off({3'b0, a1}, {3'b0, b1}, {3'b0, c1}, y1);
    chk("y_w4",   32'(y_w4),   32'(y0));
    chk("dis_w4", 32'(dis_w4), 32'(d0));
    chk("y_w1",   32'(y_w1),   32'(y1[0]));
    chk("dis_w1", 32'(dis_w1), 32'(d1));
    model_update(0, y0, d0);
    model_update(1, y1, d1);
    @(posedge clk);
    #1;
    chk("yq_w4",  32'(yq_w4), 32'(m_yq[0]));
    chk("ca_w4",  32'(ca_w4), 32'(m_cnt[0][0]));
    chk("cb_w4",  32'(cb_w4), 32'(m_cnt[0][1]));
    chk("cc_w4",  32'(cc_w4), 32'(m_cnt[0][2]));
    chk("st_w4",  32'(st_w4), 32'(m_st[0]));
    chk("yq_w1",  32'(yq_w1), 32'(m_yq[1][0]));
    chk("ca_w1",  32'(ca_w1), 32'(m_cnt[1][0]));
    chk("cb_w1",  32'(cb_w1), 32'(m_cnt[1][1]));
    chk("cc_w1",  32'(cc_w1), 32'(m_cnt[1][2]));
    chk("st_w1",  32'(st_w1), 32'(m_st[1]));
  endtask

  task automatic set_lanes(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    a4 = a; b4 = b; c4 = c;
    a1 = a[0]; b1 = b[0]; c1 = c[0];
  endtask

  initial begin
    logic [7:0] y_tab;
    logic [2:0] d_tab [8];
    logic [2:0] v;

    total = 0;
    bad   = 0;
    m_max[0] = 255;
    m_max[1] = 3;
    for (int k = 0; k < 2; k++) begin
      for (int l = 0; l < 3; l++) m_cnt[k][l] = 0;
      m_st[k] = 0;
      m_yq[k] = '0;
    end

    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    set_lanes(4'h0, 4'h0, 4'h0);

    // Reset state
    cycle();
    chk("rst_yq",  32'(yq_w4), 32'(0));
    chk("rst_cnt", 32'({ca_w4, cb_w4, cc_w4}), 32'(0));
    chk("rst_st",  32'(st_w4), 32'(0));
    rst_n = 1'b1;

    // WIDTH=1 truth table, abc ordering, diagnostics disabled
    y_tab = 8'hE8;
    d_tab = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b001, 3'b010, 3'b100, 3'b000};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; c1 = v[0];
      #1;
      chk("tt_y",   32'(y_w1),   32'(y_tab[i]));
      chk("tt_dis", 32'(dis_w1), 32'(d_tab[i]));
      cycle();
    end
    chk("tt_no_count", 32'({ca_w1, cb_w1, cc_w1, st_w1}), 32'(0));

    // Lane C faulty for 5 enabled cycles
    en = 1'b1;
    set_lanes(4'hF, 4'hF, 4'h0);
    for (int i = 0; i < 5; i++) cycle();
    chk("c5_cnt_c", 32'(cc_w4), 32'(5));
    chk("c5_cnt_a", 32'(ca_w4), 32'(0));
    chk("c5_cnt_b", 32'(cb_w4), 32'(0));
    chk("c5_st",    32'(st_w4), 32'(1));
    chk("c5_yq",    32'(yq_w4), 32'(4'hF));

    // Lane A fault for 6 cycles saturates the 2-bit counter
    clr = 1'b1; en = 1'b0;
    cycle();
    clr = 1'b0; en = 1'b1;
    set_lanes(4'h1, 4'h0, 4'h0);
    for (int i = 0; i < 6; i++) cycle();
    chk("sat_cnt_a", 32'(ca_w1), 32'(3));
    chk("sat_st",    32'(st_w1), 32'(1));

    // Clear and enable together while a fault is present
    clr = 1'b1;
    cycle();
    chk("clr_cnt", 32'({ca_w1, cb_w1, cc_w1, ca_w4, cb_w4, cc_w4}), 32'(0));
    chk("clr_st",  32'({st_w1, st_w4}), 32'(0));
    clr = 1'b0;

    // WIDTH=4: B and C fail on different bits
    set_lanes(4'hF, 4'hE, 4'h7);
    #1;
    chk("w4_y",   32'(y_w4),   32'(4'hF));
    chk("w4_dis", 32'(dis_w4), 32'(3'b110));
    cycle();
    chk("w4_cnt_b", 32'(cb_w4), 32'(1));
    chk("w4_cnt_c", 32'(cc_w4), 32'(1));
    chk("w4_cnt_a", 32'(ca_w4), 32'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_lanes(4'($urandom), 4'($urandom), 4'($urandom));
      en    = ($urandom_range(0, 9) < 7);
      clr   = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      cycle();
    end
    rst_n = 1'b1; clr = 1'b0; en = 1'b1;

    // Mid-run reset: build up state, then one reset edge
    set_lanes(4'h3, 4'hC, 4'h3);
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b0;
    set_lanes(4'hA, 4'hA, 4'h5);
    #1;
    chk("rst_y_comb", 32'(y_w4), 32'(4'hA));
    cycle();
    chk("mid_rst_yq",  32'(yq_w4), 32'(0));
    chk("mid_rst_cnt", 32'({ca_w4, cb_w4, cc_w4}), 32'(0));
    chk("mid_rst_st",  32'({st_w4, st_w1}), 32'(0));
    rst_n = 1'b1;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_majority_voter
